s_axi_write: RTL and testbench
==============================

Name: s_axi_write

Overview:
AXI4-Lite write-channel slave for the sequencer register file. It is the write-side counterpart of the AXI-Lite read slave and uses the same 16-bit address map. The block accepts AW and W in either order and decodes the address. It then issues either a single-cycle bank0 register write strobe or a req/ready write transaction to a bank1 slot, and returns a B response. Unwritable or unsupported accesses are answered with SLVERR and cause no side effect.

Parameters:
ADDR_WIDTH, 16, AXI-Lite address width
DATA_WIDTH, 32, AXI-Lite data width
BANK1_INDEX_WIDTH, 2, slot index width; index is taken from addr[BANK1_INDEX_WIDTH+6-1:6]
BANK1_FIELD_WIDTH, 4, field select width; field is taken from addr[5:2]
BANK0_SEL_WIDTH, 8, bank0 register select width; select is taken from addr[13:6]
BANK1_TIMEOUT, 16, maximum number of cycles to wait for ext_bank1_in_ready
TIMEOUT_CNT_WIDTH, 5, width of the timeout counter (must hold BANK1_TIMEOUT)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
S_AXI_AWADDR  input  ADDR_WIDTH  write address
S_AXI_AWVALID  input  1  write address valid
S_AXI_AWREADY  output  1  write address ready
S_AXI_WDATA  input  DATA_WIDTH  write data
S_AXI_WSTRB  input  DATA_WIDTH/8  byte strobes
S_AXI_WVALID  input  1  write data valid
S_AXI_WREADY  output  1  write data ready
S_AXI_BRESP  output  2  write response: 2'b00 OKAY, 2'b10 SLVERR
S_AXI_BVALID  output  1  write response valid
S_AXI_BREADY  input  1  write response ready
ext_bank0_in_we  output  1  one-cycle write strobe to bank0
ext_bank0_in_sel  output  BANK0_SEL_WIDTH  bank0 register select
ext_bank0_in_data  output  DATA_WIDTH  bank0 write data
ext_bank1_in_req  output  1  bank1 write request, held until ready or timeout
ext_bank1_in_index  output  BANK1_INDEX_WIDTH  bank1 slot index
ext_bank1_in_field  output  BANK1_FIELD_WIDTH  bank1 field select
ext_bank1_in_data  output  DATA_WIDTH  bank1 write data
ext_bank1_in_ready  input  1  bank1 write accepted

Behaviour:
- Reset (synchronous, high) puts the block in ST_IDLE and clears aw_held, w_held, the timeout counter and the latched addr/data/resp. All outputs are 0 in reset and in ST_IDLE except the ready outputs defined below.
- Reset mid-transaction abandons the transaction: no BVALID is issued and req drops on the next edge.
- States: ST_IDLE, ST_EXEC, ST_RESP.
- In ST_IDLE:
  - S_AXI_AWREADY = !aw_held. An AW handshake latches AWADDR and sets aw_held.
  - S_AXI_WREADY = !w_held. A W handshake latches WDATA and WSTRB and sets w_held.
  - AW and W may complete in the same cycle or in either order.
  - On the edge where both aw_held and w_held are set (including same-cycle handshakes), go to ST_EXEC.
- Decode, computed from the latched values on entry to ST_EXEC:
  - If WSTRB != all-ones → SLVERR, no write.
  - addr[15:14]==2'b00 (bank0): sel 0x00 (control), 0x04 (dmaBaseAddr) and 0x05 (dfxCtrlAddr) are writable. Sel 0x01–0x03 are read-only and all other sels are unmapped → SLVERR.
  - addr[15:14]==2'b01 (bank1): fields 0–3 (src_addr, src_size, des_addr, des_size) are writable. Field 4 (status) and field 5 (profile) are read-only and fields ≥6 are unmapped → SLVERR.
  - addr[15:14]==2'b1x → SLVERR.
- ST_EXEC:
  - Bank0 writable: ext_bank0_in_we=1 for exactly one cycle with sel and data valid; resp=OKAY; go to ST_RESP.
  - Bank1 writable: ext_bank1_in_req=1 with index, field and data held stable.
    - If ready=1 in a cycle where req=1 → OKAY, go to ST_RESP. Ready in the first req cycle counts.
    - The timeout counter increments each req cycle. If it reaches BANK1_TIMEOUT without ready → SLVERR, req deasserts, go to ST_RESP.
  - Error cases: one ST_EXEC cycle with no strobe or req, then ST_RESP.
- ST_RESP:
  - BVALID=1 and BRESP is stable until BREADY.
  - On the handshake: clear aw_held and w_held, go to ST_IDLE.
  - AWREADY and WREADY are 0 in ST_EXEC and ST_RESP.
- Latency, AW and W in the same cycle (cycle 0):
  - Bank0: we in cycle 1, BVALID in cycle 2.
  - Bank1: req from cycle 1; BVALID on the cycle after ready is sampled.
- Only one outstanding transaction at a time. There is no write buffering beyond the latches.

Test Plan:
- AW 0x0100 and W 0x0000000A (WSTRB 0xF) in the same cycle → we=1 in cycle 1 with sel=0x04 and data=0x0000000A; BVALID in cycle 2 with BRESP=00.
- W 0x12345678 three cycles before AW 0x4084 → WREADY drops after the W handshake, AWREADY=1. Then req=1 with index=2, field=1 and data=0x12345678; ready after 3 cycles → BRESP=00.
- AW 0x0040 (status, read-only) → no we; BRESP=10. AW 0x4050 (field 4) → no req; BRESP=10. AW 0x8000 → BRESP=10.
- WSTRB=0x3 to 0x0000 → no we; BRESP=10.
- Bank1 write with ready held 0 → req is high for exactly 16 cycles, then drops; BRESP=10.
- BREADY held low for 5 cycles → BVALID and BRESP stable and AWREADY=0 throughout. Asserting reset mid-ST_EXEC → req=0 next cycle, no BVALID, back to ST_IDLE.

Source files
------------

// File: rtl/s_axi_write.sv
// AXI4-Lite write slave for the sequencer register file: accepts AW/W in any order,
// writes bank0 via a one-cycle strobe or bank1 via req/ready, then returns a B response.
module s_axi_write #(
    parameter int ADDR_WIDTH        = 16,
    parameter int DATA_WIDTH        = 32,
    parameter int BANK1_INDEX_WIDTH = 2,
    parameter int BANK1_FIELD_WIDTH = 4,
    parameter int BANK0_SEL_WIDTH   = 8,
    parameter int BANK1_TIMEOUT     = 16,
    parameter int TIMEOUT_CNT_WIDTH = 5
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [ADDR_WIDTH-1:0]        S_AXI_AWADDR,
    input  logic                         S_AXI_AWVALID,
    output logic                         S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]        S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0]      S_AXI_WSTRB,
    input  logic                         S_AXI_WVALID,
    output logic                         S_AXI_WREADY,
    output logic [1:0]                   S_AXI_BRESP,
    output logic                         S_AXI_BVALID,
    input  logic                         S_AXI_BREADY,
    output logic                         ext_bank0_in_we,
    output logic [BANK0_SEL_WIDTH-1:0]   ext_bank0_in_sel,
    output logic [DATA_WIDTH-1:0]        ext_bank0_in_data,
    output logic                         ext_bank1_in_req,
    output logic [BANK1_INDEX_WIDTH-1:0] ext_bank1_in_index,
    output logic [BANK1_FIELD_WIDTH-1:0] ext_bank1_in_field,
    output logic [DATA_WIDTH-1:0]        ext_bank1_in_data,
    input  logic                         ext_bank1_in_ready
);

    typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESP} state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    state_t                       r_state;
    logic                         r_aw_held;
    logic                         r_w_held;
    logic [ADDR_WIDTH-1:0]        r_addr;
    logic [DATA_WIDTH-1:0]        r_data;
    logic [DATA_WIDTH/8-1:0]      r_strb;
    logic [1:0]                   r_resp;
    logic [TIMEOUT_CNT_WIDTH-1:0] r_tcnt;

    logic                         w_aw_hs;
    logic                         w_w_hs;
    logic                         w_exec;
    logic                         w_full_strb;
    logic [1:0]                   w_bank;
    logic [BANK0_SEL_WIDTH-1:0]   w_sel;
    logic [BANK1_FIELD_WIDTH-1:0] w_field;
    logic [BANK1_INDEX_WIDTH-1:0] w_index;
    logic                         w_b0_ok;
    logic                         w_b1_ok;
    logic                         w_we;
    logic                         w_req;
    logic                         w_unused;

    assign S_AXI_AWREADY = (r_state == ST_IDLE) && !r_aw_held;
    assign S_AXI_WREADY  = (r_state == ST_IDLE) && !r_w_held;
    assign w_aw_hs       = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_w_hs        = S_AXI_WVALID && S_AXI_WREADY;

    assign w_full_strb = (r_strb == '1);
    assign w_bank      = r_addr[ADDR_WIDTH-1 -: 2];
    assign w_sel       = r_addr[6 +: BANK0_SEL_WIDTH];
    assign w_field     = r_addr[2 +: BANK1_FIELD_WIDTH];
    assign w_index     = r_addr[6 +: BANK1_INDEX_WIDTH];
    assign w_unused    = ^r_addr[1:0];

    assign w_b0_ok = w_full_strb && (w_bank == 2'b00) &&
                     ((w_sel == BANK0_SEL_WIDTH'(0)) || (w_sel == BANK0_SEL_WIDTH'(4)) ||
                      (w_sel == BANK0_SEL_WIDTH'(5)));
    assign w_b1_ok = w_full_strb && (w_bank == 2'b01) && (w_field < BANK1_FIELD_WIDTH'(4));

    // Strobe/req are decoded from latched state so they appear the cycle after both halves land.
    assign w_exec = (r_state == ST_EXEC);
    assign w_we   = w_exec && w_b0_ok;
    assign w_req  = w_exec && w_b1_ok;

    assign ext_bank0_in_we    = w_we;
    assign ext_bank0_in_sel   = w_we ? w_sel : '0;
    assign ext_bank0_in_data  = w_we ? r_data : '0;
    assign ext_bank1_in_req   = w_req;
    assign ext_bank1_in_index = w_req ? w_index : '0;
    assign ext_bank1_in_field = w_req ? w_field : '0;
    assign ext_bank1_in_data  = w_req ? r_data : '0;

    assign S_AXI_BVALID = (r_state == ST_RESP);
    assign S_AXI_BRESP  = S_AXI_BVALID ? r_resp : RESP_OKAY;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_addr    <= '0;
            r_data    <= '0;
            r_strb    <= '0;
            r_resp    <= RESP_OKAY;
            r_tcnt    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_aw_hs) begin
                        r_addr    <= S_AXI_AWADDR;
                        r_aw_held <= 1'b1;
                    end
                    if (w_w_hs) begin
                        r_data   <= S_AXI_WDATA;
                        r_strb   <= S_AXI_WSTRB;
                        r_w_held <= 1'b1;
                    end
                    if ((r_aw_held || w_aw_hs) && (r_w_held || w_w_hs))
                        r_state <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (w_b0_ok) begin
                        r_resp  <= RESP_OKAY;
                        r_state <= ST_RESP;
                    end else if (w_b1_ok) begin
                        if (ext_bank1_in_ready) begin
                            r_resp  <= RESP_OKAY;
                            r_tcnt  <= '0;
                            r_state <= ST_RESP;
                        end else if (r_tcnt == TIMEOUT_CNT_WIDTH'(BANK1_TIMEOUT - 1)) begin
                            r_resp  <= RESP_SLVERR;
                            r_tcnt  <= '0;
                            r_state <= ST_RESP;
                        end else begin
                            r_tcnt <= r_tcnt + 1'b1;
                        end
                    end else begin
                        r_resp  <= RESP_SLVERR;
                        r_state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (S_AXI_BREADY) begin
                        r_aw_held <= 1'b0;
                        r_w_held  <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_s_axi_write.sv
// Self-checking bench for s_axi_write: directed scenarios plus randomized writes
// compared against an address-map model of the register file.
module tb_s_axi_write;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] S_AXI_AWADDR;
    logic        S_AXI_AWVALID;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_WVALID;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY;
    logic        ext_bank0_in_we;
    logic [7:0]  ext_bank0_in_sel;
    logic [31:0] ext_bank0_in_data;
    logic        ext_bank1_in_req;
    logic [1:0]  ext_bank1_in_index;
    logic [3:0]  ext_bank1_in_field;
    logic [31:0] ext_bank1_in_data;
    logic        ext_bank1_in_ready;

    s_axi_write #(
        .ADDR_WIDTH(16), .DATA_WIDTH(32), .BANK1_INDEX_WIDTH(2), .BANK1_FIELD_WIDTH(4),
        .BANK0_SEL_WIDTH(8), .BANK1_TIMEOUT(16), .TIMEOUT_CNT_WIDTH(5)
    ) dut (
        .clk(clk), .reset(reset),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
        .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
        .S_AXI_BREADY(S_AXI_BREADY),
        .ext_bank0_in_we(ext_bank0_in_we), .ext_bank0_in_sel(ext_bank0_in_sel),
        .ext_bank0_in_data(ext_bank0_in_data),
        .ext_bank1_in_req(ext_bank1_in_req), .ext_bank1_in_index(ext_bank1_in_index),
        .ext_bank1_in_field(ext_bank1_in_field), .ext_bank1_in_data(ext_bank1_in_data),
        .ext_bank1_in_ready(ext_bank1_in_ready)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Observations gathered by run_txn; cycle numbers are relative to the cycle
    // in which the second of AW/W handshook.
    int          o_we_cnt, o_we_cyc, o_req_cnt, o_b_cyc;
    int          o_rdy_err, o_hold_err, o_post_err;
    logic [7:0]  o_sel;
    logic [31:0] o_we_data, o_req_data;
    logic [1:0]  o_index, o_bresp;
    logic [3:0]  o_field;
    bit          o_unstable, o_timeout;

    // Address-map model: 0 = rejected (SLVERR), 1 = bank0 write, 2 = bank1 write.
    function automatic int model_kind(input logic [15:0] a, input logic [3:0] s);
        int bank  = int'(a) >> 14;
        int sel   = (int'(a) >> 6) & 255;
        int field = (int'(a) >> 2) & 15;
        if (s != 4'hF) return 0;
        if (bank == 0 && (sel == 0 || sel == 4 || sel == 5)) return 1;
        if (bank == 1 && field < 4) return 2;
        return 0;
    endfunction

    task automatic run_txn(input logic [15:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int rdy_dly, input int bready_dly);
        int c, hs_c;
        bit aw_done, w_done, aw_hs, w_hs;
        o_we_cnt = 0; o_we_cyc = -1; o_req_cnt = 0; o_b_cyc = -1;
        o_rdy_err = 0; o_hold_err = 0; o_post_err = 0;
        o_sel = '0; o_we_data = '0; o_req_data = '0; o_index = '0; o_field = '0; o_bresp = 2'b11;
        o_unstable = 0; o_timeout = 0;
        c = 0; hs_c = -1; aw_done = 0; w_done = 0;
        S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb; S_AXI_BREADY = 1'b0;
        forever begin
            S_AXI_AWVALID = !aw_done && (c >= aw_dly);
            S_AXI_WVALID  = !w_done && (c >= w_dly);
            ext_bank1_in_ready = 1'b0;
            if (hs_c < 0) begin
                if (S_AXI_AWREADY !== !aw_done || S_AXI_WREADY !== !w_done) o_rdy_err++;
            end else if (S_AXI_AWREADY !== 1'b0 || S_AXI_WREADY !== 1'b0) o_rdy_err++;
            if (ext_bank0_in_we === 1'b1) begin
                o_we_cnt++; o_we_cyc = c - hs_c; o_sel = ext_bank0_in_sel; o_we_data = ext_bank0_in_data;
            end
            if (ext_bank1_in_req === 1'b1) begin
                if (o_req_cnt == 0) begin
                    o_index = ext_bank1_in_index; o_field = ext_bank1_in_field; o_req_data = ext_bank1_in_data;
                end else if (ext_bank1_in_index !== o_index || ext_bank1_in_field !== o_field ||
                             ext_bank1_in_data !== o_req_data) o_unstable = 1;
                ext_bank1_in_ready = (o_req_cnt >= rdy_dly);
                o_req_cnt++;
            end
            if (S_AXI_BVALID === 1'b1) begin
                o_b_cyc = c - hs_c; o_bresp = S_AXI_BRESP;
                for (int k = 0; k < bready_dly; k++) begin
                    @(posedge clk); #1;
                    if (S_AXI_BVALID !== 1'b1 || S_AXI_BRESP !== o_bresp ||
                        S_AXI_AWREADY !== 1'b0 || S_AXI_WREADY !== 1'b0) o_hold_err++;
                end
                S_AXI_BREADY = 1'b1;
                @(posedge clk); #1;
                S_AXI_BREADY = 1'b0;
                if (S_AXI_BVALID !== 1'b0 || S_AXI_AWREADY !== 1'b1 || S_AXI_WREADY !== 1'b1) o_post_err++;
                break;
            end
            aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
            w_hs  = S_AXI_WVALID && S_AXI_WREADY;
            if (aw_hs) aw_done = 1;
            if (w_hs) w_done = 1;
            if (hs_c < 0 && aw_done && w_done) hs_c = c;
            @(posedge clk); #1;
            c++;
            if (c > 300) begin
                o_timeout = 1;
                break;
            end
        end
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; ext_bank1_in_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (S_AXI_BVALID !== 1'b0 || S_AXI_BRESP !== 2'b00) begin n_bad++;
            $display("FAIL reset_b: bvalid=%b bresp=%b required 0/00", S_AXI_BVALID, S_AXI_BRESP); end
        n_cmp++; if (ext_bank0_in_we !== 1'b0 || ext_bank0_in_sel !== 8'h00 || ext_bank0_in_data !== 32'h0) begin n_bad++;
            $display("FAIL reset_bank0: we=%b sel=%h data=%h required 0", ext_bank0_in_we, ext_bank0_in_sel, ext_bank0_in_data); end
        n_cmp++; if (ext_bank1_in_req !== 1'b0 || ext_bank1_in_index !== 2'b00 || ext_bank1_in_field !== 4'h0 ||
                     ext_bank1_in_data !== 32'h0) begin n_bad++;
            $display("FAIL reset_bank1: req=%b idx=%h fld=%h data=%h required 0", ext_bank1_in_req,
                     ext_bank1_in_index, ext_bank1_in_field, ext_bank1_in_data); end
        reset = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (S_AXI_AWREADY !== 1'b1 || S_AXI_WREADY !== 1'b1) begin n_bad++;
            $display("FAIL idle_ready: awready=%b wready=%b required 1/1", S_AXI_AWREADY, S_AXI_WREADY); end
    endtask

    task automatic test_bank0_same_cycle();
        run_txn(16'h0100, 32'h0000000A, 4'hF, 0, 0, 0, 0);
        n_cmp++; if (o_we_cnt != 1 || o_we_cyc != 1) begin n_bad++;
            $display("FAIL b0_we: count=%0d cycle=%0d required 1/1", o_we_cnt, o_we_cyc); end
        n_cmp++; if (o_sel !== 8'h04 || o_we_data !== 32'h0000000A) begin n_bad++;
            $display("FAIL b0_payload: sel=%h data=%h required 04/0000000a", o_sel, o_we_data); end
        n_cmp++; if (o_b_cyc != 2 || o_bresp !== 2'b00) begin n_bad++;
            $display("FAIL b0_resp: cycle=%0d bresp=%b required 2/00", o_b_cyc, o_bresp); end
        n_cmp++; if (o_rdy_err != 0 || o_post_err != 0 || o_req_cnt != 0) begin n_bad++;
            $display("FAIL b0_misc: rdy_err=%0d post_err=%0d req=%0d required 0", o_rdy_err, o_post_err, o_req_cnt); end
    endtask

    task automatic test_w_before_aw();
        run_txn(16'h4084, 32'h12345678, 4'hF, 3, 0, 3, 0);
        n_cmp++; if (o_rdy_err != 0) begin n_bad++;
            $display("FAIL wfirst_ready: violations=%0d required 0", o_rdy_err); end
        n_cmp++; if (o_index !== 2'd2 || o_field !== 4'd1 || o_req_data !== 32'h12345678 || o_unstable) begin n_bad++;
            $display("FAIL wfirst_payload: idx=%0d fld=%0d data=%h unstable=%0d required 2/1/12345678/0",
                     o_index, o_field, o_req_data, o_unstable); end
        n_cmp++; if (o_req_cnt != 4 || o_b_cyc != 5 || o_bresp !== 2'b00) begin n_bad++;
            $display("FAIL wfirst_resp: req=%0d cycle=%0d bresp=%b required 4/5/00", o_req_cnt, o_b_cyc, o_bresp); end
    endtask

    task automatic test_errors();
        logic [15:0] addrs [4] = '{16'h0040, 16'h4050, 16'h8000, 16'h0000};
        logic [3:0]  strbs [4] = '{4'hF, 4'hF, 4'hF, 4'h3};
        for (int i = 0; i < 4; i++) begin
            run_txn(addrs[i], 32'hDEADBEEF, strbs[i], i % 2, 0, 0, 0);
            n_cmp++; if (o_we_cnt != 0 || o_req_cnt != 0) begin n_bad++;
                $display("FAIL err_side[%h]: we=%0d req=%0d required 0/0", addrs[i], o_we_cnt, o_req_cnt); end
            n_cmp++; if (o_bresp !== 2'b10 || o_b_cyc != 2) begin n_bad++;
                $display("FAIL err_resp[%h]: bresp=%b cycle=%0d required 10/2", addrs[i], o_bresp, o_b_cyc); end
        end
    endtask

    task automatic test_timeout();
        run_txn(16'h40C8, 32'hCAFE0001, 4'hF, 0, 0, 1000, 0);
        n_cmp++; if (o_req_cnt != 16 || o_b_cyc != 17 || o_bresp !== 2'b10) begin n_bad++;
            $display("FAIL timeout: req=%0d cycle=%0d bresp=%b required 16/17/10", o_req_cnt, o_b_cyc, o_bresp); end
        run_txn(16'h40C8, 32'hCAFE0002, 4'hF, 0, 0, 15, 0);
        n_cmp++; if (o_req_cnt != 16 || o_b_cyc != 17 || o_bresp !== 2'b00) begin n_bad++;
            $display("FAIL last_ready: req=%0d cycle=%0d bresp=%b required 16/17/00", o_req_cnt, o_b_cyc, o_bresp); end
    endtask

    task automatic test_bready_hold();
        run_txn(16'h0000, 32'h55AA55AA, 4'hF, 1, 2, 0, 5);
        n_cmp++; if (o_hold_err != 0 || o_bresp !== 2'b00 || o_post_err != 0) begin n_bad++;
            $display("FAIL bready_hold: hold_err=%0d bresp=%b post_err=%0d required 0/00/0", o_hold_err, o_bresp, o_post_err); end
    endtask

    task automatic test_reset_mid_exec();
        int bad;
        S_AXI_AWADDR = 16'h40C0; S_AXI_WDATA = 32'h0BADF00D; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; ext_bank1_in_ready = 1'b0;
        @(posedge clk); #1;
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        n_cmp++; if (ext_bank1_in_req !== 1'b1) begin n_bad++;
            $display("FAIL rst_exec_req: req=%b required 1", ext_bank1_in_req); end
        reset = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (ext_bank1_in_req !== 1'b0 || S_AXI_BVALID !== 1'b0) begin n_bad++;
            $display("FAIL rst_exec_drop: req=%b bvalid=%b required 0/0", ext_bank1_in_req, S_AXI_BVALID); end
        reset = 1'b0;
        bad = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (S_AXI_BVALID !== 1'b0 || ext_bank1_in_req !== 1'b0 || S_AXI_AWREADY !== 1'b1 ||
                S_AXI_WREADY !== 1'b1) bad++;
        end
        n_cmp++; if (bad != 0) begin n_bad++;
            $display("FAIL rst_exec_idle: bad_cycles=%0d required 0", bad); end
    endtask

    task automatic test_random();
        logic [15:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        int bank, mid, low, rdy, kind, exp_req, exp_cyc;
        logic [1:0] exp_resp;
        for (int i = 0; i < 40; i++) begin
            bank = $urandom_range(0, 3);
            if (bank == 0) mid = ($urandom_range(0, 3) == 0) ? int'($urandom & 255) : $urandom_range(0, 7);
            else mid = int'($urandom & 255);
            if (bank == 1) low = ($urandom_range(0, 7) << 2) | int'($urandom & 3);
            else low = int'($urandom & 63);
            a = 16'((bank << 14) | (mid << 6) | low);
            d = $urandom;
            s = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'hF;
            rdy = ($urandom_range(0, 7) == 0) ? 16 + $urandom_range(0, 4) : $urandom_range(0, 6);
            run_txn(a, d, s, $urandom_range(0, 4), $urandom_range(0, 4), rdy, $urandom_range(0, 3));
            kind = model_kind(a, s);
            exp_req = 0; exp_cyc = 2; exp_resp = (kind == 0) ? 2'b10 : 2'b00;
            if (kind == 2) begin
                exp_req  = (rdy < 16) ? rdy + 1 : 16;
                exp_cyc  = (rdy < 16) ? rdy + 2 : 17;
                exp_resp = (rdy < 16) ? 2'b00 : 2'b10;
            end
            n_cmp++; if (o_bresp !== exp_resp || o_b_cyc != exp_cyc || o_timeout) begin n_bad++;
                $display("FAIL rnd_resp[%0d] addr=%h strb=%h: bresp=%b cycle=%0d to=%0d required %b/%0d/0",
                         i, a, s, o_bresp, o_b_cyc, o_timeout, exp_resp, exp_cyc); end
            n_cmp++; if (o_we_cnt != (kind == 1 ? 1 : 0) || o_req_cnt != exp_req) begin n_bad++;
                $display("FAIL rnd_side[%0d] addr=%h: we=%0d req=%0d required %0d/%0d",
                         i, a, o_we_cnt, o_req_cnt, (kind == 1 ? 1 : 0), exp_req); end
            if (kind == 1) begin
                n_cmp++; if (o_sel !== 8'(mid) || o_we_data !== d || o_we_cyc != 1) begin n_bad++;
                    $display("FAIL rnd_b0[%0d]: sel=%h data=%h cyc=%0d required %h/%h/1", i, o_sel, o_we_data,
                             o_we_cyc, 8'(mid), d); end
            end
            if (kind == 2) begin
                n_cmp++; if (o_index !== 2'(mid & 3) || o_field !== 4'(low >> 2) || o_req_data !== d || o_unstable) begin
                    n_bad++;
                    $display("FAIL rnd_b1[%0d]: idx=%0d fld=%0d data=%h unstable=%0d required %0d/%0d/%h/0",
                             i, o_index, o_field, o_req_data, o_unstable, mid & 3, low >> 2, d); end
            end
            n_cmp++; if (o_rdy_err != 0 || o_hold_err != 0 || o_post_err != 0) begin n_bad++;
                $display("FAIL rnd_hs[%0d]: rdy_err=%0d hold_err=%0d post_err=%0d required 0",
                         i, o_rdy_err, o_hold_err, o_post_err); end
        end
    endtask

    initial begin
        reset = 1'b1;
        S_AXI_AWADDR = '0; S_AXI_AWVALID = 1'b0; S_AXI_WDATA = '0; S_AXI_WSTRB = '0;
        S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0; ext_bank1_in_ready = 1'b0;
        test_reset();
        test_bank0_same_cycle();
        test_w_before_aw();
        test_errors();
        test_timeout();
        test_bready_hold();
        test_reset_mid_exec();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
